// File: rtl/param_sync_fifo.sv
// Parameterised single-clock FIFO with fill-level flags, sticky error flags and
// a choice of registered-read or first-word-fall-through output.
module param_sync_fifo #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = 14,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     full,
  output logic                     almost_full,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     empty,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              r_overflow;
  logic              r_underflow;
  logic              w_wr_acc;
  logic              w_rd_acc;

  // Accept decisions use the flags decoded from the count held before the edge.
  assign w_wr_acc = wr_en & ~full  & ~flush;
  assign w_rd_acc = rd_en & ~empty & ~flush;

  assign full         = (r_count == CW'(DEPTH));
  assign empty        = (r_count == {CW{1'b0}});
  assign almost_full  = (r_count >= CW'(AF_THRESH));
  assign almost_empty = (r_count <= CW'(AE_THRESH));
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

  // Storage array; contents are meaningful only between the pointers.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  // Pointers, fill level and sticky error flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr    <= {AW{1'b0}};
      r_rd_ptr    <= {AW{1'b0}};
      r_count     <= {CW{1'b0}};
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (flush) begin
      r_wr_ptr    <= {AW{1'b0}};
      r_rd_ptr    <= {AW{1'b0}};
      r_count     <= {CW{1'b0}};
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (wr_en && full) begin
        r_overflow <= 1'b1;
      end
      if (rd_en && empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is visible without a read strobe; don't-care while empty.
      assign rd_data = r_mem[r_rd_ptr];
    end else begin : g_reg
      logic [DATA_W-1:0] r_rd_data;

      // Registered read port: loads the head word on an accepted read only.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_rd_data <= {DATA_W{1'b0}};
        end else if (w_rd_acc) begin
          r_rd_data <= r_mem[r_rd_ptr];
        end else begin
          r_rd_data <= r_rd_data;
        end
      end

      assign rd_data = r_rd_data;
    end
  endgenerate

endmodule

// File: doc/param_sync_fifo.md
PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 The block SHALL provide parameter DATA_W, default 8, data word width in bits (>=1).
REQ-002 The block SHALL provide parameter DEPTH, default 16, number of storage entries (power of two, >=2).
REQ-003 The block SHALL provide parameter AF_THRESH, default 14, almost_full asserts when count >= AF_THRESH.
REQ-004 The block SHALL provide parameter AE_THRESH, default 2, almost_empty asserts when count <= AE_THRESH.
REQ-005 The block SHALL provide parameter FWFT, default 0, where 0 is registered-read mode and 1 is first-word-fall-through mode.
REQ-006 The block SHALL have one clock and an asynchronous, active-low reset; the ports are clk and reset_n.
REQ-007 The block SHALL provide these ports:
  clk           input   1                    sole clock, rising edge
  reset_n       input   1                    async active-low reset
  flush         input   1                    sync clear of contents and error flags
  wr_en         input   1                    write request
  wr_data       input   DATA_W               write word
  full          output  1                    count == DEPTH
  almost_full   output  1                    count >= AF_THRESH
  rd_en         input   1                    read/pop request
  rd_data       output  DATA_W               read word
  empty         output  1                    count == 0
  almost_empty  output  1                    count <= AE_THRESH
  count         output  log2(DEPTH)+1        current fill level
  overflow      output  1                    sticky: write rejected
  underflow     output  1                    sticky: read rejected

Function
REQ-008 A write SHALL be accepted on a clk edge iff wr_en=1, full=0 and flush=0; an accepted write stores wr_data at the write pointer and advances that pointer modulo DEPTH.
REQ-009 A read SHALL be accepted on a clk edge iff rd_en=1, empty=0 and flush=0; an accepted read advances the read pointer modulo DEPTH.
REQ-010 Accept decisions SHALL use the flag values from before the edge: when full, a simultaneous read is accepted and the write is rejected; when empty, a simultaneous write is accepted and the read is rejected.
REQ-011 count SHALL be incremented on a write-only accept, decremented on a read-only accept, and left unchanged when both or neither are accepted; it never exceeds DEPTH or goes below 0.
REQ-012 full, empty, almost_full and almost_empty SHALL be combinational decodes of the registered count, with no added latency.
REQ-013 With FWFT=0, rd_data SHALL load the head word on the edge that accepts a read (one-cycle latency) and hold its value otherwise.
REQ-014 With FWFT=1, rd_data SHALL present the head word combinationally whenever empty=0; it is valid the cycle after a write into an empty FIFO, and rd_en pops that word.
REQ-015 With FWFT=1 and empty=1, rd_data SHALL be don't-care, and the bench checks it only when empty=0.
REQ-016 Pointers SHALL wrap from DEPTH-1 to 0 with no loss or duplication of data across the wrap.
REQ-017 overflow SHALL set on any edge with wr_en=1, full=1 and flush=0, and hold until flush or reset.
REQ-018 underflow SHALL set on any edge with rd_en=1, empty=1 and flush=0, and hold until flush or reset.
REQ-019 flush=1 SHALL have priority over wr_en and rd_en: on that edge both pointers and count go to 0, overflow and underflow clear, no write or read is accepted, and rd_data holds its value in FWFT=0 mode.
REQ-020 Storage contents SHALL NOT need clearing on flush or reset; only pointers and count define valid data.

Reset
REQ-021 reset_n=0 SHALL asynchronously force pointers=0, count=0, overflow=0, underflow=0 and rd_data=0 (FWFT=0), giving empty=1, almost_empty=1, full=0 and almost_full=0.
REQ-022 Reset asserted mid-operation SHALL discard all stored words; after release the FIFO behaves as freshly reset from the first rising clk edge.

Verification
REQ-023 The bench SHALL cover: defaults, reset, write 0x01..0x10 (16 words) -> full=1 after the 16th, almost_full=1 from count=14, count=16; read all 16 -> rd_data 0x01..0x10 in order, empty=1.
REQ-024 The bench SHALL cover: full FIFO, wr_en=1 with wr_data=0xAA and rd_en=0 for one cycle -> overflow=1, count=16, 0xAA never read; then flush=1 -> count=0, overflow=0, empty=1.
REQ-025 The bench SHALL cover: empty FIFO, rd_en=1 -> underflow=1, rd_data unchanged; simultaneous wr_en=1 with 0x5C and rd_en=1 when empty -> write accepted, count=1.
REQ-026 The bench SHALL cover: count=8, wr_en=1 and rd_en=1 for 20 cycles with an incrementing pattern -> count stays 8, pointers wrap, output order exact.
REQ-027 The bench SHALL cover: FWFT=1, write 0x3C into empty FIFO -> next cycle empty=0 and rd_data=0x3C before any rd_en; rd_en=1 -> empty=1.
REQ-028 The bench SHALL cover: reset_n asserted low mid-clock with count=5 -> count=0 and empty=1 immediately, without waiting for a clk edge.
